pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken branches/jumps from EX, and multi-cycle data-memory accesses through a valid/ready handshake with a timeout watchdog. It also maintains saturating performance counters for stall, flush and load-use events.

---
 rtl/pipeline_hazard_controller.sv | 134 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. It handles load-use hazards, taken branches
// from EX and multi-cycle data-memory accesses, and keeps saturating event counters.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  r1_reg_idx_id,
    input  logic [4:0]  r2_reg_idx_id,
    input  logic        rs1_used_id,
    input  logic        rs2_used_id,
    input  logic        mem_do_read_ctrl_ex,
    input  logic [4:0]  wr_reg_idx_ex,
    input  logic        branch_taken_ex,
    input  logic        dmem_req_mem,
    input  logic        dmem_ready,
    output logic        dmem_valid,
    output logic        pc_enable,
    output logic        if_id_enable,
    output logic        id_ex_enable,
    output logic        ex_mem_enable,
    output logic        mem_wb_enable,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic        mem_timeout_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] load_use_count,
    output logic        debug_state
);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        mem_stall;
    logic        load_use;
    logic        sel_branch;
    logic        sel_load_use;

    // Memory handshake: dmem_valid mirrors the MEM request. The access completes in the cycle
    // where dmem_valid and dmem_ready are both high.
    assign mem_stall   = dmem_req_mem & ~dmem_ready;
    assign dmem_valid  = dmem_req_mem;
    assign debug_state = (state == MEM_WAIT);

    assign load_use = mem_do_read_ctrl_ex && (wr_reg_idx_ex != 5'd0) &&
                      ((rs1_used_id && (r1_reg_idx_id == wr_reg_idx_ex)) ||
                       (rs2_used_id && (r2_reg_idx_id == wr_reg_idx_ex)));

    always_comb begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        id_ex_enable  = 1'b1;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_flush  = 1'b0;
        sel_branch    = 1'b0;
        sel_load_use  = 1'b0;
        if (mem_stall) begin
            // Freeze everything. A bubble goes into WB, and any branch or load-use stays pending.
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
            mem_wb_flush  = 1'b1;
        end else if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            sel_branch  = 1'b1;
        end else if (load_use) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
            sel_load_use = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= RUN;
            wait_cnt        <= 16'd0;
            mem_timeout_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 16'd1;
                    end else begin
                        wait_cnt <= 16'd0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_stall) begin
                        if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
                        // The flag is sticky. The pipeline stays frozen and is not recovered here.
                        if (wait_cnt == TIMEOUT_LAST) mem_timeout_err <= 1'b1;
                    end else begin
                        // This covers both a completed access and a request that was dropped.
                        state    <= RUN;
                        wait_cnt <= 16'd0;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= 16'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cycles   <= 32'd0;
            flush_count    <= 32'd0;
            load_use_count <= 32'd0;
        end else begin
            if (!pc_enable && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (sel_branch && flush_count != 32'hFFFF_FFFF)
                flush_count <= flush_count + 32'd1;
            if (sel_load_use && load_use_count != 32'hFFFF_FFFF)
                load_use_count <= load_use_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed test of the hazard controller: load-use, branch priority, memory stalls, the
// watchdog and reset in the middle of a wait.
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  r1_reg_idx_id, r2_reg_idx_id, wr_reg_idx_ex;
    logic        rs1_used_id, rs2_used_id, mem_do_read_ctrl_ex;
    logic        branch_taken_ex, dmem_req_mem, dmem_ready;
    logic        dmem_valid, pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
    logic        if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout_err, debug_state;
    logic [31:0] stall_cycles, flush_count, load_use_count;

    int tests_run = 0;
    int tests_failed = 0;

    pipeline_hazard_controller #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .resetn(resetn),
        .r1_reg_idx_id(r1_reg_idx_id), .r2_reg_idx_id(r2_reg_idx_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .mem_do_read_ctrl_ex(mem_do_read_ctrl_ex), .wr_reg_idx_ex(wr_reg_idx_ex),
        .branch_taken_ex(branch_taken_ex), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .dmem_valid(dmem_valid), .pc_enable(pc_enable), .if_id_enable(if_id_enable),
        .id_ex_enable(id_ex_enable), .ex_mem_enable(ex_mem_enable), .mem_wb_enable(mem_wb_enable),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
        .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles),
        .flush_count(flush_count), .load_use_count(load_use_count), .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The enables are packed as {pc, if_id, id_ex, ex_mem, mem_wb}.
    // The flushes are packed as {if_id, id_ex, mem_wb}.
    task automatic chk_ctl(input string tag, input logic [4:0] en, input logic [2:0] fl);
        #1;
        chk({tag, "_en"}, 32'({pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable}), 32'(en));
        chk({tag, "_fl"}, 32'({if_id_flush, id_ex_flush, mem_wb_flush}), 32'(fl));
    endtask

    task automatic idle();
        r1_reg_idx_id = 5'd0; r2_reg_idx_id = 5'd0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
        mem_do_read_ctrl_ex = 1'b0; wr_reg_idx_ex = 5'd0; branch_taken_ex = 1'b0;
        dmem_req_mem = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        mem_do_read_ctrl_ex = 1'b1; wr_reg_idx_ex = rd; r1_reg_idx_id = rd; rs1_used_id = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        step();
        step();
        chk_ctl("reset_idle", 5'b11111, 3'b000);
        resetn = 1'b1;
        chk("reset_stall", stall_cycles, 32'd0);
        chk("reset_flush", flush_count, 32'd0);
        chk("reset_lu", load_use_count, 32'd0);
        chk("reset_err", 32'(mem_timeout_err), 32'd0);
        chk("reset_state", 32'(debug_state), 32'd0);

        // Load to x5 in EX while ID reads rs1 = x5 gives exactly one bubble.
        set_load_use(5'd5);
        chk_ctl("lu_rs1", 5'b00111, 3'b010);
        step();
        idle();
        chk_ctl("lu_after", 5'b11111, 3'b000);
        chk("lu_count1", load_use_count, 32'd1);
        chk("lu_stall1", stall_cycles, 32'd1);

        // A load to x0 is never a hazard.
        mem_do_read_ctrl_ex = 1'b1; wr_reg_idx_ex = 5'd0; rs1_used_id = 1'b1; rs2_used_id = 1'b1;
        chk_ctl("x0", 5'b11111, 3'b000);
        step();
        idle();
        chk("x0_lu", load_use_count, 32'd1);

        // When a branch and a load-use happen together, the branch wins.
        set_load_use(5'd9);
        branch_taken_ex = 1'b1;
        chk_ctl("br_lu", 5'b11111, 3'b110);
        step();
        idle();
        chk("br_flush", flush_count, 32'd1);
        chk("br_lu_cnt", load_use_count, 32'd1);
        chk("br_stall", stall_cycles, 32'd1);

        // Load-use detected through rs2.
        mem_do_read_ctrl_ex = 1'b1; wr_reg_idx_ex = 5'd7; r2_reg_idx_id = 5'd7; rs2_used_id = 1'b1;
        r1_reg_idx_id = 5'd7;
        chk_ctl("lu_rs2", 5'b00111, 3'b010);
        step();
        idle();
        chk("lu_count2", load_use_count, 32'd2);
        chk("lu_stall2", stall_cycles, 32'd2);

        // Memory access ready on cycle 4: three frozen cycles, then release.
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        chk_ctl("mw_c1", 5'b00000, 3'b001);
        chk("mw_valid", 32'(dmem_valid), 32'd1);
        chk("mw_state_c1", 32'(debug_state), 32'd0);
        step();
        chk("mw_state_c2", 32'(debug_state), 32'd1);
        chk_ctl("mw_c2", 5'b00000, 3'b001);
        step();
        chk("mw_state_c3", 32'(debug_state), 32'd1);
        step();
        dmem_ready = 1'b1;
        chk_ctl("mw_c4", 5'b11111, 3'b000);
        chk("mw_state_c4", 32'(debug_state), 32'd1);
        step();
        idle();
        chk("mw_state_after", 32'(debug_state), 32'd0);
        chk("mw_stall", stall_cycles, 32'd5);
        chk("mw_err", 32'(mem_timeout_err), 32'd0);

        // A single-cycle access causes no stall.
        dmem_req_mem = 1'b1; dmem_ready = 1'b1;
        chk_ctl("single", 5'b11111, 3'b000);
        step();
        idle();
        chk("single_state", 32'(debug_state), 32'd0);
        chk("single_stall", stall_cycles, 32'd5);

        // A branch held through a memory stall is applied once, in the release cycle.
        dmem_req_mem = 1'b1; dmem_ready = 1'b0; branch_taken_ex = 1'b1;
        chk_ctl("mbr_c1", 5'b00000, 3'b001);
        step();
        chk_ctl("mbr_c2", 5'b00000, 3'b001);
        step();
        dmem_ready = 1'b1;
        chk_ctl("mbr_rel", 5'b11111, 3'b110);
        step();
        idle();
        chk("mbr_flush", flush_count, 32'd2);
        chk("mbr_stall", stall_cycles, 32'd7);
        chk("mbr_state", 32'(debug_state), 32'd0);

        // If the request is dropped during MEM_WAIT, the controller returns to RUN without a flag.
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        step();
        chk("drop_wait", 32'(debug_state), 32'd1);
        dmem_req_mem = 1'b0;
        chk_ctl("drop_ctl", 5'b11111, 3'b000);
        step();
        chk("drop_state", 32'(debug_state), 32'd0);
        chk("drop_err", 32'(mem_timeout_err), 32'd0);
        chk("drop_stall", stall_cycles, 32'd8);

        // With MEM_TIMEOUT = 4, the flag rises at the edge that ends the 4th stall cycle.
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        step();
        step();
        step();
        chk("to_c3_err", 32'(mem_timeout_err), 32'd0);
        chk_ctl("to_frozen", 5'b00000, 3'b001);
        step();
        chk("to_c4_err", 32'(mem_timeout_err), 32'd1);
        chk("to_stall", stall_cycles, 32'd12);
        step();
        chk("to_sticky_wait", 32'(mem_timeout_err), 32'd1);
        dmem_ready = 1'b1;
        step();
        idle();
        chk("to_sticky_ready", 32'(mem_timeout_err), 32'd1);
        chk("to_state", 32'(debug_state), 32'd0);

        // Reset asserted in the middle of MEM_WAIT.
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        step();
        chk("rst_wait", 32'(debug_state), 32'd1);
        resetn = 1'b0;
        chk_ctl("rst_comb", 5'b00000, 3'b001);
        step();
        chk("rst_state", 32'(debug_state), 32'd0);
        chk("rst_err", 32'(mem_timeout_err), 32'd0);
        chk("rst_stall", stall_cycles, 32'd0);
        chk("rst_flush", flush_count, 32'd0);
        chk("rst_lu", load_use_count, 32'd0);
        idle();
        resetn = 1'b1;
        step();
        chk("post_rst_state", 32'(debug_state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
